// File: rtl/static_buff_pkg.sv
// Shared types and default widths for the static_buff initiator-side controller.
package static_buff_pkg;

    typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_e;

    // $clog2 floored at 1 so single-entry configurations still get a usable field width.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int NUMELEM_DEF = 4;
    localparam int NUMFIFO_DEF = 8;
    localparam int BITFIFO     = clog2_min1(NUMFIFO_DEF);
    localparam int BITELEM     = clog2_min1(NUMELEM_DEF);

endpackage

// File: rtl/static_buff_ctrl_if.sv
// Producer, consumer and buffer-command signals of static_buff_ctrl.
interface static_buff_ctrl_if #(
    parameter int NUMFIFO = 8,
    parameter int BITDATA = 4,
    parameter int BITFIFO = (NUMFIFO > 1) ? $clog2(NUMFIFO) : 1
);
    logic               enq_vld;
    logic [BITFIFO-1:0] enq_prt;
    logic [BITDATA-1:0] enq_din;
    logic               enq_rdy;
    logic [NUMFIFO-1:0] deq_req;
    logic               deq_vld;
    logic [BITFIFO-1:0] deq_prt;
    logic [BITDATA-1:0] deq_dout;
    logic [NUMFIFO-1:0] full;
    logic [NUMFIFO-1:0] empty;
    logic               buf_ready;
    logic               push;
    logic [BITFIFO-1:0] pu_prt;
    logic [BITDATA-1:0] pu_din;
    logic               pop;
    logic [BITFIFO-1:0] po_prt;
    logic [BITDATA-1:0] po_dout;

    modport master (
        input  enq_vld, enq_prt, enq_din, deq_req, buf_ready, po_dout,
        output enq_rdy, deq_vld, deq_prt, deq_dout, full, empty,
               push, pu_prt, pu_din, pop, po_prt
    );

    modport slave (
        output enq_vld, enq_prt, enq_din, deq_req, buf_ready, po_dout,
        input  enq_rdy, deq_vld, deq_prt, deq_dout, full, empty,
               push, pu_prt, pu_din, pop, po_prt
    );
endinterface

// File: rtl/static_buff_ctrl_rr_arb.sv
// Round-robin arbiter: lowest request at or after the pointer wins; pointer moves past the winner.
module rr_arb #(
    parameter int N = 8,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic         gnt_vld,
    output logic [W-1:0] gnt_idx
);
    logic [W-1:0] ptr_q, ptr_d;
    logic [W-1:0] idx;

    always_comb begin
        gnt_vld = |req;
        gnt_idx = '0;
        idx     = '0;
        // Scan from farthest to nearest so the closest requester to ptr is the last write.
        for (int k = N - 1; k >= 0; k--) begin
            idx = W'((int'(ptr_q) + k) % N);
            if (req[idx]) gnt_idx = idx;
        end
        ptr_d = ptr_q;
        if (gnt_vld) ptr_d = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
endmodule

// File: rtl/static_buff_ctrl.sv
// Initiator controller for static_buff: shadow occupancy, legal push/pop, round-robin pops
// and a RDLAT-deep return pipe that tags po_dout as a valid dequeue beat.
module static_buff_ctrl
    import static_buff_pkg::*;
#(
    parameter int NUMELEM = 4,
    parameter int BITDATA = 4,
    parameter int NUMFIFO = 8,
    parameter int RDLAT   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    static_buff_ctrl_if.master   bus
);
    localparam int PRT_W = clog2_min1(NUMFIFO);
    localparam int CNT_W = clog2_min1(NUMELEM) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUMELEM);

    state_e                          state_q, state_d;
    logic [NUMFIFO-1:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic [RDLAT-1:0]                ret_vld_q, ret_vld_d;
    logic [RDLAT-1:0][PRT_W-1:0]     ret_prt_q, ret_prt_d;

    logic               run, enq_rdy, push, pop, deq_vld, inc, dec;
    logic [NUMFIFO-1:0] full_v, empty_v, cand;
    logic               gnt_vld;
    logic [PRT_W-1:0]   gnt_idx;

    always_comb begin
        for (int i = 0; i < NUMFIFO; i++) begin
            full_v[i]  = (cnt_q[i] == CNT_MAX);
            empty_v[i] = (cnt_q[i] == '0);
        end
    end

    // Everything is held off while rst is high so the reset cycle itself shows reset values.
    assign run     = (state_q == RUN) && !rst;
    assign enq_rdy = run && !full_v[bus.enq_prt];
    assign push    = bus.enq_vld && enq_rdy;
    // Candidates use pre-push counts: a FIFO being filled this cycle is not yet poppable.
    assign cand    = run ? (bus.deq_req & ~empty_v) : '0;

    rr_arb #(.N(NUMFIFO), .W(PRT_W)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (cand),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    assign pop = gnt_vld;

    always_comb begin
        state_d = state_q;
        if (state_q == INIT && bus.buf_ready) state_d = RUN;

        cnt_d = cnt_q;
        inc   = 1'b0;
        dec   = 1'b0;
        for (int i = 0; i < NUMFIFO; i++) begin
            inc = push && (bus.enq_prt == PRT_W'(i));
            dec = pop  && (gnt_idx     == PRT_W'(i));
            if (inc && !dec)      cnt_d[i] = cnt_q[i] + CNT_W'(1);
            else if (dec && !inc) cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end

        ret_vld_d    = ret_vld_q;
        ret_prt_d    = ret_prt_q;
        ret_vld_d[0] = pop;
        ret_prt_d[0] = gnt_idx;
        for (int i = 1; i < RDLAT; i++) begin
            ret_vld_d[i] = ret_vld_q[i-1];
            ret_prt_d[i] = ret_prt_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= INIT;
            cnt_q     <= '0;
            ret_vld_q <= '0;
            ret_prt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ret_vld_q <= ret_vld_d;
            ret_prt_q <= ret_prt_d;
        end
    end

    assign deq_vld      = ret_vld_q[RDLAT-1] && !rst;
    assign bus.deq_vld  = deq_vld;
    assign bus.deq_prt  = deq_vld ? ret_prt_q[RDLAT-1] : '0;
    assign bus.deq_dout = deq_vld ? bus.po_dout : '0;

    assign bus.enq_rdy = enq_rdy;
    assign bus.full    = full_v;
    assign bus.empty   = empty_v;
    assign bus.push    = push;
    assign bus.pu_prt  = bus.enq_prt;
    assign bus.pu_din  = bus.enq_din;
    assign bus.pop     = pop;
    assign bus.po_prt  = gnt_idx;
endmodule

// File: tb/tb_static_buff_ctrl.sv
// Directed bench for static_buff_ctrl with a small behavioural static_buff model (RDLAT=1).
module tb_static_buff_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    static_buff_ctrl_if #(.NUMFIFO(8), .BITDATA(4)) bus ();

    static_buff_ctrl #(.NUMELEM(4), .BITDATA(4), .NUMFIFO(8), .RDLAT(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Stand-in buffer: 8 FIFOs x 4 entries, one-cycle registered read data.
    logic [3:0] mem [8][4];
    logic [1:0] wp [8];
    logic [1:0] rp [8];
    logic [3:0] po_q;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                wp[i] <= 2'd0;
                rp[i] <= 2'd0;
            end
            po_q <= 4'd0;
        end else begin
            if (bus.push) begin
                mem[bus.pu_prt][wp[bus.pu_prt]] <= bus.pu_din;
                wp[bus.pu_prt] <= wp[bus.pu_prt] + 2'd1;
            end
            if (bus.pop) begin
                po_q <= mem[bus.po_prt][rp[bus.po_prt]];
                rp[bus.po_prt] <= rp[bus.po_prt] + 2'd1;
            end
        end
    end

    assign bus.po_dout = po_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] pprt [4];
        logic [3:0] pdat [4];
        logic [2:0] gprt [4];
        logic [3:0] gdat [4];
        pprt = '{3'd0, 3'd0, 3'd2, 3'd5};
        pdat = '{4'hA, 4'hB, 4'hC, 4'hD};
        gprt = '{3'd0, 3'd2, 3'd5, 3'd0};
        gdat = '{4'hA, 4'hC, 4'hD, 4'hB};

        rst = 1'b1;
        bus.enq_vld = 1'b0; bus.enq_prt = '0; bus.enq_din = '0;
        bus.deq_req = '0;   bus.buf_ready = 1'b0;
        repeat (2) cyc();

        bus.enq_vld = 1'b1; bus.deq_req = 8'hFF;
        #1;
        chk("rst_enq_rdy", 32'(bus.enq_rdy), 32'd0);
        chk("rst_empty",   32'(bus.empty),   32'hFF);
        chk("rst_full",    32'(bus.full),    32'h00);
        chk("rst_deq_vld", 32'(bus.deq_vld), 32'd0);
        chk("rst_pop",     32'(bus.pop),     32'd0);

        rst = 1'b0;
        cyc();
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("init_enq_rdy", 32'(bus.enq_rdy), 32'd0);
            chk("init_push",    32'(bus.push),    32'd0);
            chk("init_pop",     32'(bus.pop),     32'd0);
            cyc();
        end
        bus.buf_ready = 1'b1; bus.enq_vld = 1'b0; bus.deq_req = '0;
        #1;
        chk("init_last_enq_rdy", 32'(bus.enq_rdy), 32'd0);
        cyc();
        bus.buf_ready = 1'b0;
        #1;
        chk("run_enq_rdy", 32'(bus.enq_rdy), 32'd1);

        // Fill FIFO 3 with 1..4.
        for (int k = 0; k < 4; k++) begin
            bus.enq_vld = 1'b1; bus.enq_prt = 3'd3; bus.enq_din = 4'(k + 1);
            #1;
            chk("fill_push",   32'(bus.push),   32'd1);
            chk("fill_pu_din", 32'(bus.pu_din), 32'(k + 1));
            cyc();
        end
        bus.enq_din = 4'd5;
        #1;
        chk("full3",         32'(bus.full[3]),  32'd1);
        chk("full3_enq_rdy", 32'(bus.enq_rdy),  32'd0);
        chk("full3_no_push", 32'(bus.push),     32'd0);
        bus.enq_vld = 1'b0; bus.enq_prt = 3'd0;
        #1;
        chk("other_enq_rdy", 32'(bus.enq_rdy), 32'd1);

        // Drain FIFO 3; data must come back in order.
        for (int k = 0; k < 4; k++) begin
            bus.deq_req = 8'h08;
            #1;
            chk("drain_pop",    32'(bus.pop),    32'd1);
            chk("drain_po_prt", 32'(bus.po_prt), 32'd3);
            cyc();
            chk("drain_deq_vld",  32'(bus.deq_vld),  32'd1);
            chk("drain_deq_prt",  32'(bus.deq_prt),  32'd3);
            chk("drain_deq_dout", 32'(bus.deq_dout), 32'(k + 1));
        end
        bus.deq_req = '0;
        #1;
        chk("drain_empty3", 32'(bus.empty[3]), 32'd1);

        // Push/pop FIFO 7 once so the arbiter pointer wraps to 0.
        bus.enq_vld = 1'b1; bus.enq_prt = 3'd7; bus.enq_din = 4'h9;
        cyc();
        bus.enq_vld = 1'b0; bus.deq_req = 8'h80;
        #1;
        chk("wrap_po_prt", 32'(bus.po_prt), 32'd7);
        cyc();
        bus.deq_req = '0;
        chk("wrap_deq_dout", 32'(bus.deq_dout), 32'h9);

        for (int k = 0; k < 4; k++) begin
            bus.enq_vld = 1'b1; bus.enq_prt = pprt[k]; bus.enq_din = pdat[k];
            cyc();
        end
        bus.enq_vld = 1'b0;

        // Round-robin across FIFOs 0, 2, 5 with all requests raised.
        for (int k = 0; k < 4; k++) begin
            bus.deq_req = 8'hFF;
            #1;
            chk("rr_pop",    32'(bus.pop),    32'd1);
            chk("rr_po_prt", 32'(bus.po_prt), 32'(gprt[k]));
            cyc();
            chk("rr_deq_vld",  32'(bus.deq_vld),  32'd1);
            chk("rr_deq_prt",  32'(bus.deq_prt),  32'(gprt[k]));
            chk("rr_deq_dout", 32'(bus.deq_dout), 32'(gdat[k]));
        end
        #1;
        chk("rr_idle_pop", 32'(bus.pop),   32'd0);
        chk("rr_empty",    32'(bus.empty), 32'hFF);
        bus.deq_req = '0;

        // FIFO 1: same-cycle push and pop keep the count at 1.
        bus.enq_vld = 1'b1; bus.enq_prt = 3'd1; bus.enq_din = 4'h5;
        cyc();
        bus.enq_din = 4'h7; bus.deq_req = 8'h02;
        #1;
        chk("pp_push",   32'(bus.push),   32'd1);
        chk("pp_pop",    32'(bus.pop),    32'd1);
        chk("pp_po_prt", 32'(bus.po_prt), 32'd1);
        cyc();
        bus.enq_vld = 1'b0;
        #1;
        chk("pp_dout_old", 32'(bus.deq_dout), 32'h5);
        chk("pp_pop2",     32'(bus.pop),      32'd1);
        cyc();
        chk("pp_dout_new", 32'(bus.deq_dout), 32'h7);
        chk("pp_empty1",   32'(bus.empty[1]), 32'd1);
        chk("pp_no_pop",   32'(bus.pop),      32'd0);
        bus.deq_req = '0;

        // Push into empty FIFO 4 with a standing request: pop waits a cycle.
        bus.enq_vld = 1'b1; bus.enq_prt = 3'd4; bus.enq_din = 4'h6; bus.deq_req = 8'h10;
        #1;
        chk("e4_push",   32'(bus.push), 32'd1);
        chk("e4_no_pop", 32'(bus.pop),  32'd0);
        cyc();
        bus.enq_vld = 1'b0;
        #1;
        chk("e4_pop",    32'(bus.pop),    32'd1);
        chk("e4_po_prt", 32'(bus.po_prt), 32'd4);
        cyc();
        bus.deq_req = '0;
        chk("e4_deq_vld",  32'(bus.deq_vld),  32'd1);
        chk("e4_deq_dout", 32'(bus.deq_dout), 32'h6);

        // Reset right after a pop discards the in-flight beat and clears counts.
        bus.enq_vld = 1'b1; bus.enq_prt = 3'd6; bus.enq_din = 4'h3;
        cyc();
        bus.enq_prt = 3'd0; bus.enq_din = 4'h1;
        cyc();
        bus.enq_vld = 1'b0; bus.deq_req = 8'h40;
        #1;
        chk("mr_pop",    32'(bus.pop),    32'd1);
        chk("mr_po_prt", 32'(bus.po_prt), 32'd6);
        cyc();
        rst = 1'b1; bus.deq_req = '0;
        #1;
        chk("mr_deq_vld_in_rst", 32'(bus.deq_vld), 32'd0);
        cyc();
        rst = 1'b0;
        #1;
        chk("mr_deq_vld_after", 32'(bus.deq_vld), 32'd0);
        chk("mr_empty",         32'(bus.empty),   32'hFF);
        chk("mr_full",          32'(bus.full),    32'h00);
        bus.enq_vld = 1'b1; bus.enq_prt = 3'd0;
        #1;
        chk("mr_init_enq_rdy", 32'(bus.enq_rdy), 32'd0);
        bus.buf_ready = 1'b1;
        cyc();
        bus.buf_ready = 1'b0; bus.enq_vld = 1'b0;
        #1;
        chk("mr_run_enq_rdy", 32'(bus.enq_rdy), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/static_buff_ctrl.md
# static_buff_ctrl

Initiator-side controller for the multi-FIFO `static_buff`. It turns a producer's valid/ready enqueue stream and a consumer's per-queue dequeue requests into legal `push`/`pop` commands. It keeps shadow occupancy counts so the buffer never overflows or underflows, and arbitrates pops round-robin. It also re-times `po_dout` into a valid-tagged dequeue output. It sits directly in front of `static_buff`, with matching parameters.

## Interface
Parameters:
- NUMELEM, 4, entries per FIFO; must match the buffer.
- BITDATA, 4, element width.
- NUMFIFO, 8, number of FIFOs.
- RDLAT, 1, buffer read latency in cycles from `pop` to valid `po_dout`; must be ≥1.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- enq_vld  in  1  producer has an element.
- enq_prt  in  BITFIFO  target FIFO.
- enq_din  in  BITDATA  element data.
- enq_rdy  out  1  element accepted this cycle when `enq_vld` is also high.
- deq_req  in  NUMFIFO  per-FIFO consumer request vector; level-sensitive.
- deq_vld  out  1  `deq_dout` valid.
- deq_prt  out  BITFIFO  FIFO the data came from.
- deq_dout  out  BITDATA  popped element.
- full  out  NUMFIFO  per-FIFO count == NUMELEM.
- empty  out  NUMFIFO  per-FIFO count == 0.
- buf_ready  in  1  buffer `ready`.
- push, pu_prt, pu_din  out  1/BITFIFO/BITDATA  buffer push command.
- pop, po_prt  out  1/BITFIFO  buffer pop command.
- po_dout  in  BITDATA  buffer read data.

## Operation
- FSM states: INIT, RUN.
  - Reset enters INIT.
  - INIT goes to RUN on the first cycle `buf_ready` == 1.
  - RUN is left only by `rst`. `buf_ready` is ignored in RUN.
- In INIT:
  - `enq_rdy`, `push`, `pop` are 0.
  - `deq_req` is ignored.
- Shadow counts: `cnt[i]`, width BITELEM+1, reset 0.
  - `full[i]`/`empty[i]` are decoded combinationally from `cnt[i]`.
- Enqueue:
  - `enq_rdy` = RUN && !full[enq_prt].
  - `push` = enq_vld && enq_rdy.
  - `pu_prt`/`pu_din` pass through from `enq_prt`/`enq_din`.
- Pop arbitration:
  - Candidates = `deq_req` & ~empty, using counts before this cycle's push.
  - A round-robin arbiter grants one candidate per cycle.
  - The priority pointer moves to grant+1 mod NUMFIFO after each grant; it is unchanged with no grant.
  - `pop` = RUN && any candidate; `po_prt` = grant index.
- Count update per FIFO:
  - push only: +1.
  - pop only: −1.
  - push and pop on the same FIFO in one cycle: unchanged.
  - A push into an empty FIFO cannot be popped in the same cycle.
- Read return: a RDLAT-deep shift register carries (pop, po_prt).
  - Its output drives `deq_vld`/`deq_prt`.
  - `deq_dout` = `po_dout`, qualified by `deq_vld`.
  - There is no backpressure on the dequeue output; the consumer must accept every `deq_vld` beat.
- Invariants that must hold:
  - Never push a full FIFO.
  - Never pop an empty FIFO.
  - `cnt[i]` ≤ NUMELEM.

## Timing
- Reset values:
  - All outputs 0 except `empty`, which is all-ones.
  - All counts 0; pointer 0; return pipeline cleared.
- `enq_rdy`, `push`, `pop`, `full`, `empty` are combinational from registered state plus current inputs.
- Counts update on the edge after a push/pop.
- `deq_vld` rises exactly RDLAT cycles after `pop`.
- Throughput: one push and one pop per cycle.
- Reset mid-operation:
  - In-flight return beats are discarded; `deq_vld` is 0 the cycle after `rst`.
  - The block returns to INIT and re-waits for `buf_ready`.

## Structure
- `static_buff_pkg`:
  - State enum {INIT, RUN}.
  - Width localparams BITFIFO/BITELEM via `$clog2`.
- Sub-module `rr_arb` (NUMFIFO-wide request/grant with registered pointer), instantiated once.
- Counts and return pipeline are inline.

## Test plan
- Reset, hold `buf_ready`=0 for 5 cycles, then raise it → `enq_rdy`=0 throughout INIT; `enq_rdy`=1 the cycle after `buf_ready`.
- Push 4 elements (1,2,3,4) to FIFO 3 → `full[3]`=1 and `enq_rdy`=0 for `enq_prt`=3; a fifth push is not issued.
- `deq_req`=8'hFF with FIFOs 0, 2, 5 non-empty → pops granted 0, 2, 5, 0 on consecutive cycles; `deq_vld` follows each pop by RDLAT with matching `deq_prt`.
- FIFO 1 holds 1 element; same-cycle push 7 and pop on FIFO 1 → count stays 1; `deq_dout` returns the older element, then 7 on the next pop.
- Empty FIFO 4 with `deq_req[4]`=1 and push to FIFO 4 → no pop that cycle; pop occurs the next cycle.
- Assert `rst` one cycle after a pop → `deq_vld` never rises for it; all counts 0 and `empty` all-ones.
